// File: rtl/mtl2_pkg.sv
// Shared definitions for the MTL2 LED sequencer: register map, bit positions and FSM encoding.
package mtl2_pkg;

  localparam int unsigned NUM_STEPS_DEF = 8;
  localparam int unsigned LED_WIDTH_DEF = 10;
  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned M_ADDR_W      = 2;

  // s0 word offsets
  localparam logic [ADDR_W-1:0] REG_CTRL     = 4'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 4'd1;
  localparam logic [ADDR_W-1:0] REG_PERIOD   = 4'd2;
  localparam logic [ADDR_W-1:0] REG_LENGTH   = 4'd3;
  localparam logic [ADDR_W-1:0] REG_PAT_BASE = 4'd8;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_LOOP    = 1;
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_IDX_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mtl2_led_step_timer.sv
// Loadable down-counter that paces the gap between LED steps; saturates at zero.
module mtl2_led_step_timer
  import mtl2_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero_c
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mtl2_led_sequencer.sv
// Steps a CPU-programmed LED pattern table and writes each pattern to the LED PIO over Avalon-MM.
module mtl2_led_sequencer
  import mtl2_pkg::*;
#(
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEF,
  parameter int unsigned LED_WIDTH = LED_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_chipselect,
  input  logic                s0_write_n,
  input  logic [DATA_W-1:0]   s0_writedata,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic [M_ADDR_W-1:0] m_address,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest
);

  localparam int unsigned IW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  seq_state_e           state_q;
  logic                 run_q;
  logic                 loop_q;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [DATA_W-1:0]    length_q;
  logic [IW-1:0]        idx_q;
  logic [LED_WIDTH-1:0] pat_q [NUM_STEPS];

  logic                 wr_c;
  logic                 wr_ctrl_c;
  logic                 pat_hit_c;
  logic [IW-1:0]        pat_idx_c;
  logic [IW-1:0]        len_last_c;
  logic                 at_end_c;
  logic [CNT_WIDTH-1:0] tmr_load_val_c;
  logic                 tmr_zero_c;

  // s0 decode
  assign wr_c      = s0_chipselect & ~s0_write_n;
  assign wr_ctrl_c = wr_c && (s0_address == REG_CTRL);
  assign pat_hit_c = (s0_address >= REG_PAT_BASE) &&
                     (32'(s0_address - REG_PAT_BASE) < NUM_STEPS);
  assign pat_idx_c = IW'(s0_address - REG_PAT_BASE);

  // LENGTH of 0 or beyond the table depth means the whole table
  assign len_last_c = ((length_q == '0) || (length_q > 32'(NUM_STEPS)))
                    ? IW'(NUM_STEPS - 1)
                    : IW'(length_q - 32'd1);
  assign at_end_c   = (idx_q >= len_last_c);

  assign tmr_load_val_c = (period_q == '0) ? '0 : (period_q - CNT_WIDTH'(1));

  assign m_address = '0;

  mtl2_led_step_timer #(
    .WIDTH (CNT_WIDTH)
  ) u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (state_q == ST_LOAD),
    .load_value (tmr_load_val_c),
    .en         (state_q == ST_WAIT),
    .zero_c     (tmr_zero_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      period_q    <= '0;
      length_q    <= '0;
      idx_q       <= '0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        pat_q[i] <= '0;
      end
    end else begin
      // CPU register writes; FSM updates below take priority except for CTRL
      if (wr_ctrl_c) begin
        run_q  <= s0_writedata[CTRL_RUN];
        loop_q <= s0_writedata[CTRL_LOOP];
      end
      if (wr_c && (s0_address == REG_STATUS)) begin
        done_q <= 1'b0;
      end
      if (wr_c && (s0_address == REG_PERIOD)) begin
        period_q <= CNT_WIDTH'(s0_writedata);
      end
      if (wr_c && (s0_address == REG_LENGTH)) begin
        length_q <= s0_writedata;
      end
      if (wr_c && pat_hit_c) begin
        pat_q[pat_idx_c] <= LED_WIDTH'(s0_writedata);
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_ctrl_c && s0_writedata[CTRL_RUN] && !run_q) begin
            idx_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          m_writedata <= DATA_W'(pat_q[idx_q]);
          m_write     <= 1'b1;
          state_q     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!run_q) begin
            state_q <= ST_IDLE;
          end else if (tmr_zero_c) begin
            if (!at_end_c) begin
              idx_q   <= idx_q + IW'(1);
              state_q <= ST_LOAD;
            end else if (loop_q) begin
              idx_q   <= '0;
              state_q <= ST_LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              if (!wr_ctrl_c) begin
                run_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // zero-wait-state read mux
  always_comb begin
    s0_readdata = '0;
    if (pat_hit_c) begin
      s0_readdata[LED_WIDTH-1:0] = pat_q[pat_idx_c];
    end else begin
      case (s0_address)
        REG_CTRL: begin
          s0_readdata[CTRL_RUN]  = run_q;
          s0_readdata[CTRL_LOOP] = loop_q;
        end
        REG_STATUS: begin
          s0_readdata[STAT_BUSY]            = (state_q != ST_IDLE);
          s0_readdata[STAT_DONE]            = done_q;
          s0_readdata[STAT_IDX_LSB +: IW]   = idx_q;
        end
        REG_PERIOD: s0_readdata[CNT_WIDTH-1:0] = period_q;
        REG_LENGTH: s0_readdata = length_q;
        default:    s0_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mtl2_led_sequencer.sv
// Directed bench for mtl2_led_sequencer: CPU register writes on s0, PIO write capture on the master port.
module tb_mtl2_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  s0_address;
  logic        s0_chipselect;
  logic        s0_write_n;
  logic [31:0] s0_writedata;
  logic [31:0] s0_readdata;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_cyc = 0;
  logic [31:0] acc_val [$];
  int          acc_cyc [$];

  always #5 clk = ~clk;

  mtl2_led_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s0_address    (s0_address),
    .s0_chipselect (s0_chipselect),
    .s0_write_n    (s0_write_n),
    .s0_writedata  (s0_writedata),
    .s0_readdata   (s0_readdata),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  // PIO side: log every accepted write with the edge number it was accepted on
  always @(posedge clk) begin
    if (reset_n === 1'b1 && m_write === 1'b1 && m_waitrequest === 1'b0) begin
      acc_val.push_back(m_writedata);
      acc_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    s0_address    = a;
    s0_writedata  = d;
    s0_chipselect = 1'b1;
    s0_write_n    = 1'b0;
    wr_cyc        = cyc;
    @(posedge clk);
    #1;
    s0_chipselect = 1'b0;
    s0_write_n    = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    s0_address = a;
    #1;
    d = s0_readdata;
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (acc_val.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (acc_val.size() >= n);
  endtask

  task automatic wait_mwrite(input int budget, output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (m_write !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (m_write === 1'b1);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [3:0]  addrs [5];
    addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (m_write !== 1'b0 || m_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_init: m_write=%b m_writedata=%h expected 0/0", m_write, m_writedata);
    end
    // Start a run against a stalled PIO, then reset in the middle of the WRITE
    cpu_write(4'd8, 32'h2AA);
    cpu_write(4'd2, 32'd7);
    cpu_write(4'd3, 32'd5);
    m_waitrequest = 1'b1;
    cpu_write(4'd0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_write !== 1'b1 || m_writedata !== 32'h2AA) begin
      errors++;
      $display("FAIL reset_prewrite: m_write=%b data=%h expected 1/2aa", m_write, m_writedata);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0 || m_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_midwrite: m_write=%b data=%h expected 0/0", m_write, m_writedata);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    foreach (addrs[i]) begin
      cpu_read(addrs[i], rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: read %h expected 0", addrs[i], rd);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    logic [31:0] exp_v [3];
    bit ok;
    int t0;
    exp_v = '{32'h001, 32'h002, 32'h3FF};
    cpu_write(4'd8, 32'h001);
    cpu_write(4'd9, 32'h002);
    cpu_write(4'd10, 32'h3FF);
    cpu_write(4'd3, 32'd3);
    cpu_write(4'd2, 32'd4);
    acc_val.delete();
    acc_cyc.delete();
    cpu_write(4'd0, 32'h1);
    t0 = wr_cyc;
    wait_acc(3, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oneshot_timeout: got %0d writes expected 3", acc_val.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_val[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL oneshot_val%0d: got %h expected %h", i, acc_val[i], exp_v[i]);
      end
    end
    checks++;
    if (acc_cyc[0] - t0 != 2) begin
      errors++;
      $display("FAIL oneshot_latency: got %0d expected 2", acc_cyc[0] - t0);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
        errors++;
        $display("FAIL oneshot_spacing%0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    repeat (10) @(negedge clk);
    cpu_read(4'd1, rd);
    checks++;
    if (rd !== 32'h22) begin
      errors++;
      $display("FAIL oneshot_status: got %h expected 22", rd);
    end
    cpu_read(4'd0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL oneshot_ctrl: got %h expected 0", rd);
    end
    checks++;
    if (acc_val.size() != 3 || m_writedata !== 32'h3FF) begin
      errors++;
      $display("FAIL oneshot_hold: writes=%0d data=%h expected 3/3ff", acc_val.size(), m_writedata);
    end
  endtask

  task automatic test_loop();
    logic [31:0] rd;
    logic [31:0] exp_v [7];
    bit ok;
    exp_v = '{32'h001, 32'h002, 32'h3FF, 32'h001, 32'h002, 32'h3FF, 32'h001};
    cpu_write(4'd1, 32'h0);
    acc_val.delete();
    acc_cyc.delete();
    cpu_write(4'd0, 32'h3);
    wait_acc(7, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_timeout: got %0d writes expected 7", acc_val.size());
      return;
    end
    cpu_write(4'd0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (acc_val[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL loop_val%0d: got %h expected %h", i, acc_val[i], exp_v[i]);
      end
    end
    checks++;
    if (acc_cyc[3] - acc_cyc[2] != 6) begin
      errors++;
      $display("FAIL loop_wrap_spacing: got %0d expected 6", acc_cyc[3] - acc_cyc[2]);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (acc_val.size() != 7 || m_writedata !== 32'h001 || m_write !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: writes=%0d data=%h m_write=%b expected 7/001/0",
               acc_val.size(), m_writedata, m_write);
    end
    cpu_read(4'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL loop_status: got %h expected 0", rd);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stable;
    acc_val.delete();
    acc_cyc.delete();
    cpu_write(4'd0, 32'h1);
    wait_acc(1, 50, ok);
    m_waitrequest = 1'b1;
    wait_mwrite(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_no_write: m_write=%b expected 1", m_write);
      m_waitrequest = 1'b0;
      return;
    end
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (m_write !== 1'b1 || m_writedata !== 32'h002) stable = 1'b0;
    end
    m_waitrequest = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall_stable: m_write=%b data=%h expected held 1/002 for 6 clks", m_write, m_writedata);
    end
    wait_acc(3, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_timeout: got %0d writes expected 3", acc_val.size());
      return;
    end
    checks++;
    if (acc_val[1] !== 32'h002 || acc_cyc[1] - acc_cyc[0] != 11) begin
      errors++;
      $display("FAIL stall_accept: data=%h gap=%0d expected 002/11", acc_val[1], acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (acc_cyc[2] - acc_cyc[1] != 6) begin
      errors++;
      $display("FAIL stall_after: gap=%0d expected 6", acc_cyc[2] - acc_cyc[1]);
    end
    repeat (10) @(negedge clk);
    cpu_write(4'd1, 32'h0);
  endtask

  task automatic test_period0();
    logic [31:0] rd;
    logic [31:0] exp_v [8];
    bit ok;
    for (int i = 0; i < 8; i++) begin
      exp_v[i] = (32'h001 << i) | 32'h200;
      cpu_write(4'(8 + i), exp_v[i]);
    end
    cpu_write(4'd2, 32'd0);
    cpu_write(4'd3, 32'd0);
    acc_val.delete();
    acc_cyc.delete();
    cpu_write(4'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      wait_acc(k + 1, 20, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL period0_timeout: got %0d writes expected %0d", acc_val.size(), k + 1);
        return;
      end
      s0_address = 4'd1;
      #1;
      checks++;
      if (s0_readdata[6:4] !== 3'(k)) begin
        errors++;
        $display("FAIL period0_idx%0d: got %0d expected %0d", k, s0_readdata[6:4], k);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_val[i] !== exp_v[i] || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 3)) begin
        errors++;
        $display("FAIL period0_step%0d: data=%h gap=%0d expected %h/3", i, acc_val[i],
                 (i > 0) ? acc_cyc[i] - acc_cyc[i-1] : 3, exp_v[i]);
      end
    end
    repeat (10) @(negedge clk);
    cpu_read(4'd1, rd);
    checks++;
    if (rd !== 32'h72 || acc_val.size() != 8) begin
      errors++;
      $display("FAIL period0_end: status=%h writes=%0d expected 72/8", rd, acc_val.size());
    end
    cpu_write(4'd1, 32'h0);
  endtask

  task automatic test_pattern_update();
    bit ok;
    cpu_write(4'd8, 32'h001);
    cpu_write(4'd9, 32'h002);
    cpu_write(4'd10, 32'h3FF);
    cpu_write(4'd3, 32'd3);
    cpu_write(4'd2, 32'd2);
    acc_val.delete();
    acc_cyc.delete();
    cpu_write(4'd0, 32'h3);
    wait_acc(1, 50, ok);
    m_waitrequest = 1'b1;
    wait_mwrite(30, ok);
    cpu_write(4'd9, 32'h155);
    @(negedge clk);
    m_waitrequest = 1'b0;
    wait_acc(5, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL patupd_timeout: got %0d writes expected 5", acc_val.size());
      m_waitrequest = 1'b0;
      return;
    end
    checks++;
    if (acc_val[1] !== 32'h002) begin
      errors++;
      $display("FAIL patupd_first: got %h expected 002", acc_val[1]);
    end
    checks++;
    if (acc_val[3] !== 32'h001 || acc_val[4] !== 32'h155) begin
      errors++;
      $display("FAIL patupd_second: got %h,%h expected 001,155", acc_val[3], acc_val[4]);
    end
    cpu_write(4'd0, 32'h0);
    repeat (15) @(negedge clk);
    s0_address = 4'd1;
    #1;
    checks++;
    if (s0_readdata[0] !== 1'b0) begin
      errors++;
      $display("FAIL patupd_idle: busy=%b expected 0", s0_readdata[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    s0_address    = 4'd0;
    s0_chipselect = 1'b0;
    s0_write_n    = 1'b1;
    s0_writedata  = 32'h0;
    m_waitrequest = 1'b0;
    test_reset();
    test_oneshot();
    test_loop();
    test_stall();
    test_period0();
    test_pattern_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
